// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter and fixed-latency sequencer for the shared SOPC RAM.
// Define MEM_ARB_RR_EN for round-robin tie-break; default is data-port priority.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_sel,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_ack,
    output logic                ram_ce,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_sel,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                stall_req
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       gnt_mem;
    logic       pick_mem;

`ifdef MEM_ARB_RR_EN
    logic last_mem;

    always_comb begin
        pick_mem = mem_req;
        if (if_req && mem_req) begin
            pick_mem = ~last_mem;
        end
    end
`else
    always_comb begin
        pick_mem = mem_req;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt_mem   <= 1'b0;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_sel   <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
`ifdef MEM_ARB_RR_EN
            last_mem  <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (if_req || mem_req) begin
                        gnt_mem <= pick_mem;
                        ram_ce  <= 1'b1;
                        cnt     <= CNT_INIT;
                        state   <= ACCESS;
`ifdef MEM_ARB_RR_EN
                        last_mem <= pick_mem;
`endif
                        if (pick_mem) begin
                            ram_we    <= mem_we;
                            ram_addr  <= mem_addr;
                            ram_wdata <= mem_wdata;
                            ram_sel   <= mem_sel;
                        end else begin
                            ram_we    <= 1'b0;
                            ram_addr  <= if_addr;
                            ram_wdata <= '0;
                            ram_sel   <= '1;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        ram_ce <= 1'b0;
                        state  <= RESP;
                        if (gnt_mem) begin
                            mem_ack <= 1'b1;
                            if (!ram_we) begin
                                mem_rdata <= ram_rdata;
                            end
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= ram_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if_ack  <= 1'b0;
                    mem_ack <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: W=2 main instance, W=1 instance
// for back-to-back fetch timing.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic          if_req, mem_req, mem_we;
    logic [AW-1:0] if_addr, mem_addr, ram_addr;
    logic [DW-1:0] mem_wdata, if_rdata, mem_rdata, ram_wdata, ram_rdata;
    logic [SW-1:0] mem_sel, ram_sel;
    logic          if_ack, mem_ack, ram_ce, ram_we, stall_req;

    logic          if_req1, mem_req1, mem_we1;
    logic [AW-1:0] if_addr1, mem_addr1, ram_addr1;
    logic [DW-1:0] mem_wdata1, if_rdata1, mem_rdata1, ram_wdata1, ram_rdata1;
    logic [SW-1:0] mem_sel1, ram_sel1;
    logic          if_ack1, mem_ack1, ram_ce1, ram_we1, stall_req1;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h4) return 32'h3402_0011;
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    assign ram_rdata  = ram_ce  ? word(ram_addr)  : 32'hBAD0_BAD0;
    assign ram_rdata1 = ram_ce1 ? word(ram_addr1) : 32'hBAD0_BAD0;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .ram_ce(ram_ce), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_sel(ram_sel),
        .ram_rdata(ram_rdata), .stall_req(stall_req)
    );

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_sel(mem_sel1), .mem_rdata(mem_rdata1),
        .mem_ack(mem_ack1), .ram_ce(ram_ce1), .ram_we(ram_we1),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_sel(ram_sel1),
        .ram_rdata(ram_rdata1), .stall_req(stall_req1)
    );

    typedef struct {
        logic        is_mem;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] if_model, mem_model;

    // Scoreboard: every ack on the W=2 instance must match the head entry.
    always @(negedge clk) begin : sb
        exp_t e;
        logic [31:0] got;
        if (if_ack || mem_ack) begin
            checks++;
            got = mem_ack ? mem_rdata : if_rdata;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: if_ack=%0b mem_ack=%0b cyc=%0d, required no ack",
                         if_ack, mem_ack, cyc);
            end else begin
                e = exp_q.pop_front();
                if (mem_ack !== e.is_mem || if_ack !== !e.is_mem ||
                    got !== e.data || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL sb_ack: got mem=%0b if=%0b data=%h cyc=%0d, required mem=%0b data=%h cyc=%0d",
                             mem_ack, if_ack, got, cyc, e.is_mem, e.data, e.cyc);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        if_req = 0; if_addr = '0;
        mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0; mem_sel = '0;
        if_req1 = 0; if_addr1 = '0;
        mem_req1 = 0; mem_we1 = 0; mem_addr1 = '0; mem_wdata1 = '0; mem_sel1 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (ram_ce !== 1'b0) begin
            errors++; $display("FAIL reset_ce: got %b required 0", ram_ce);
        end
        checks++;
        if ({ram_we, ram_addr, ram_wdata, ram_sel} !== '0) begin
            errors++; $display("FAIL reset_ram: got we=%b addr=%h wd=%h sel=%h required 0",
                               ram_we, ram_addr, ram_wdata, ram_sel);
        end
        checks++;
        if ({if_ack, mem_ack} !== 2'b00) begin
            errors++; $display("FAIL reset_ack: got %b%b required 00", if_ack, mem_ack);
        end
        checks++;
        if (if_rdata !== '0 || mem_rdata !== '0) begin
            errors++; $display("FAIL reset_rdata: got %h %h required 0 0", if_rdata, mem_rdata);
        end
        checks++;
        if (stall_req !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b required 0", stall_req);
        end
        rst = 1'b0;
        if_model = '0;
        mem_model = '0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int c0;
        if_addr = 32'h4;
        if_req = 1'b1;
        c0 = cyc;
        if_model = 32'h3402_0011;
        exp_q.push_back('{1'b0, 32'h3402_0011, c0 + 3});
        #1;
        checks++;
        if (stall_req !== 1'b1) begin
            errors++; $display("FAIL fetch_stall_c0: got %b required 1", stall_req);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (ram_ce !== (k <= 2)) begin
                errors++; $display("FAIL fetch_ce_c%0d: got %b required %b", k, ram_ce, k <= 2);
            end
            if (k <= 2) begin
                checks++;
                if (ram_addr !== 32'h4 || ram_we !== 1'b0 || ram_sel !== 4'hF) begin
                    errors++; $display("FAIL fetch_bus_c%0d: got addr=%h we=%b sel=%h required 4 0 f",
                                       k, ram_addr, ram_we, ram_sel);
                end
            end
            checks++;
            if (stall_req !== (k <= 2)) begin
                errors++; $display("FAIL fetch_stall_c%0d: got %b required %b", k, stall_req, k <= 2);
            end
            if (if_ack) if_req = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL fetch_pending: got %0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_mem_read();
        int c0;
        mem_we = 1'b0;
        mem_addr = 32'h200;
        mem_sel = 4'hF;
        mem_req = 1'b1;
        c0 = cyc;
        mem_model = word(32'h200);
        exp_q.push_back('{1'b1, word(32'h200), c0 + 3});
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) mem_addr = 32'h300;
            if (k <= 2) begin
                checks++;
                if (ram_addr !== 32'h200 || ram_we !== 1'b0 || ram_ce !== 1'b1) begin
                    errors++; $display("FAIL rd_bus_c%0d: got addr=%h we=%b ce=%b required 200 0 1",
                                       k, ram_addr, ram_we, ram_ce);
                end
            end
            if (mem_ack) mem_req = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rd_pending: got %0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_write();
        int c0;
        mem_we = 1'b1;
        mem_addr = 32'h100;
        mem_wdata = 32'hDEAD_BEEF;
        mem_sel = 4'b0011;
        mem_req = 1'b1;
        c0 = cyc;
        exp_q.push_back('{1'b1, mem_model, c0 + 3});
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 2) begin
                checks++;
                if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_sel !== 4'b0011 ||
                    ram_addr !== 32'h100 || ram_wdata !== 32'hDEAD_BEEF) begin
                    errors++; $display("FAIL wr_bus_c%0d: got ce=%b we=%b sel=%b addr=%h wd=%h required 1 1 0011 100 deadbeef",
                                       k, ram_ce, ram_we, ram_sel, ram_addr, ram_wdata);
                end
            end
            if (mem_ack) mem_req = 1'b0;
        end
        mem_we = 1'b0;
        checks++;
        if (if_rdata !== if_model) begin
            errors++; $display("FAIL wr_if_hold: got %h required %h", if_rdata, if_model);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL wr_pending: got %0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_contention();
        int c0;
        int acks;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if_model = '0;
        mem_model = '0;
        @(negedge clk);
        if_addr = 32'h20;
        mem_addr = 32'h40;
        mem_we = 1'b0;
        mem_sel = 4'hF;
        if_req = 1'b1;
        mem_req = 1'b1;
        c0 = cyc;
        acks = 0;
`ifdef MEM_ARB_RR_EN
        exp_q.push_back('{1'b0, word(32'h20), c0 + 3});
        exp_q.push_back('{1'b1, word(32'h40), c0 + 7});
        exp_q.push_back('{1'b0, word(32'h20), c0 + 11});
        exp_q.push_back('{1'b1, word(32'h40), c0 + 15});
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (ram_addr !== 32'h20) begin
                    errors++; $display("FAIL arb_first: got addr=%h required 20", ram_addr);
                end
            end
            if (if_ack || mem_ack) acks++;
            if (acks == 4) begin
                if_req = 1'b0;
                mem_req = 1'b0;
            end
        end
`else
        exp_q.push_back('{1'b1, word(32'h40), c0 + 3});
        exp_q.push_back('{1'b0, word(32'h20), c0 + 7});
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (ram_addr !== 32'h40) begin
                    errors++; $display("FAIL arb_first: got addr=%h required 40", ram_addr);
                end
            end
            if (if_ack) if_req = 1'b0;
            if (mem_ack) mem_req = 1'b0;
        end
`endif
        if_model = word(32'h20);
        mem_model = word(32'h40);
        checks++;
        if (exp_q.size() != 0 || if_req || mem_req) begin
            errors++; $display("FAIL arb_pending: got %0d left required 0", exp_q.size());
            exp_q.delete();
            if_req = 1'b0;
            mem_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int c1;
        if_addr = 32'h8;
        if_req = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_ce !== 1'b1) begin
            errors++; $display("FAIL rstmid_ce_c1: got %b required 1", ram_ce);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ram_ce !== 1'b0) begin
            errors++; $display("FAIL rstmid_ce_drop: got %b required 0", ram_ce);
        end
        checks++;
        if (if_rdata !== '0 || mem_rdata !== '0 || ram_addr !== '0 || {if_ack, mem_ack} !== 2'b00) begin
            errors++; $display("FAIL rstmid_outs: got ifd=%h md=%h addr=%h acks=%b%b required zeros",
                               if_rdata, mem_rdata, ram_addr, if_ack, mem_ack);
        end
        @(negedge clk);
        rst = 1'b0;
        c1 = cyc;
        if_model = word(32'h8);
        exp_q.push_back('{1'b0, word(32'h8), c1 + 3});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (if_ack) if_req = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rstmid_pending: got %0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        int n;
        if_addr1 = 32'h10;
        if_req1 = 1'b1;
        c0 = cyc;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (if_ack1) begin
                checks++;
                if (cyc - c0 !== 2 + 3 * n || if_rdata1 !== word(32'h10)) begin
                    errors++; $display("FAIL b2b_ack%0d: got cyc=%0d data=%h required cyc=%0d data=%h",
                                       n, cyc - c0, if_rdata1, 2 + 3 * n, word(32'h10));
                end
                n++;
                if (n == 3) if_req1 = 1'b0;
            end
        end
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL b2b_count: got %0d required 3", n);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fetch();
        test_mem_read();
        test_write();
        test_contention();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL final_pending: got %0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and sequencer that shares the single SOPC memory between the instruction-fetch port and the data (load/store) port of the CPU pipeline. Each port issues a level request; the block grants one port at a time, drives a fixed-latency single-port RAM for `WAIT_CYCLES` cycles, returns read data with a one-cycle acknowledge, and raises a stall request to the pipeline controller while any request is outstanding. It sits inside the SOPC between the CPU core and the data/instruction RAM.

## Interface
- `ADDR_W`, 32, address width of both ports and RAM
- `DATA_W`, 32, data width
- `WAIT_CYCLES`, 2, cycles `ram_ce` is held per access; legal range 1..15
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `if_req`  in  1  fetch request, level, held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched word, valid when `if_ack`=1
- `if_ack`  out  1  one-cycle fetch done pulse
- `mem_req`  in  1  data request, level, held until `mem_ack`
- `mem_we`  in  1  1 = write, 0 = read
- `mem_addr`  in  ADDR_W  data address
- `mem_wdata`  in  DATA_W  write data
- `mem_sel`  in  DATA_W/8  byte enables
- `mem_rdata`  out  DATA_W  read word, valid when `mem_ack`=1
- `mem_ack`  out  1  one-cycle data done pulse
- `ram_ce`, `ram_we`  out  1  RAM chip enable / write enable
- `ram_addr`  out  ADDR_W; `ram_wdata`  out  DATA_W; `ram_sel`  out  DATA_W/8
- `ram_rdata`  in  DATA_W  RAM read data, valid on last access cycle
- `stall_req`  out  1  pipeline stall request

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any request, select grantee, register its address/wdata/sel/we onto `ram_*`, load counter = WAIT_CYCLES-1, go ACCESS. Fetch accesses force `ram_we`=0, `ram_sel`=all ones.
- ACCESS: `ram_ce`=1, `ram_*` stable. Counter decrements each cycle; at 0, capture `ram_rdata` into grantee's rdata register (reads only), go RESP.
- RESP: `ram_ce`=0, grantee's ack=1 for exactly this cycle, go IDLE. Requests are not sampled in RESP.
- Writes: `mem_ack` pulses; `mem_rdata` keeps previous value.
- `if_rdata`/`mem_rdata` hold until overwritten by that port's next read.
- `stall_req` = (`if_req` & ~`if_ack`) | (`mem_req` & ~`mem_ack`), combinational.
- Request changes while not granted or mid-access are ignored; latched address is used.
- Reset values: state IDLE, counter 0, all `ram_*` 0, both acks 0, both rdata 0, last-grant = MEM.
- Reset asserted mid-access: immediate return to IDLE, `ram_ce` drops asynchronously, no ack issued; requester reissues after reset (partial write permitted).

## Timing
- Request first sampled in IDLE at cycle 0 -> `ram_ce` high cycles 1..W -> ack in cycle W+1. Latency W+1 per access, W+2 cycle occupancy including IDLE.
- Requester must drop req in the cycle after ack (cycle W+2, IDLE) or it is taken as a new transfer.
- Losing port waits; its grant starts the IDLE cycle after the winner's RESP.
- Simultaneous requests: resolved per Configuration.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin; on tie, grant the port not granted last; last-grant updates on every grant; reset last-grant = MEM so fetch wins the first tie.
- Not defined: fixed priority, data port always wins ties; last-grant register omitted.

## Test plan
- Reset then single fetch, `if_addr`=0x4, RAM word 0x3402_0011, W=2 -> `ram_ce` cycles 1-2, `if_ack`=1 cycle 3 with `if_rdata`=0x3402_0011, `stall_req` high cycles 0-2.
- Data write `mem_addr`=0x100, `mem_wdata`=0xDEAD_BEEF, `mem_sel`=4'b0011 -> `ram_we`=1, `ram_sel`=0011 during ACCESS, `mem_ack` cycle 3, `mem_rdata` unchanged.
- Both requests held continuously, no RR -> grants MEM then IF; acks cycles 3 and 7; with `MEM_ARB_RR_EN` -> IF first (cycle 3), MEM second (cycle 7), then alternating.
- `rst` asserted in cycle 2 of an access -> `ram_ce`=0 same cycle, no ack, all outputs at reset values; after release, held request completes normally.
- WAIT_CYCLES=1 back-to-back fetches, req held through ack -> acks every 3 cycles (cycles 2, 5, 8).
